// File: rtl/wb_stage.sv
// ============================================================================
// Module   : wb_stage
// Purpose  : Writeback stage: load extraction, writeback mux, register-file
//            write port, cycle/instret counters and the tohost CSR.
// Options  : WB_LOAD_MISALIGN_CHECK_EN enables the misaligned-load trap flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage #(
  parameter int unsigned DWIDTH      = 32,
  parameter logic [11:0] TOHOST_ADDR = 12'h51E
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DWIDTH-1:0] pc,
  input  logic [DWIDTH-1:0] alu,
  input  logic [2:0]        LDSel,
  input  logic [1:0]        WBSel,
  input  logic              RegWen,
  input  logic [31:0]       inst,
  input  logic [DWIDTH-1:0] dmem_dout,
  input  logic              counter_clr,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic [DWIDTH-1:0] rf_wd,
  output logic [DWIDTH-1:0] cycle_cnt,
  output logic [DWIDTH-1:0] instret_cnt,
  output logic [DWIDTH-1:0] tohost,
  output logic              misalign_err
);

  localparam logic [6:0] c_OPC_SYSTEM = 7'h73;
  localparam logic [2:0] c_LD_LB      = 3'b000;
  localparam logic [2:0] c_LD_LH      = 3'b001;
  localparam logic [2:0] c_LD_LBU     = 3'b100;
  localparam logic [2:0] c_LD_LHU     = 3'b101;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DWIDTH-1:0] w_load;
  logic              w_misalign;
  logic              w_tohost_wr;

  logic [DWIDTH-1:0] cycle_q, cycle_d;
  logic [DWIDTH-1:0] instret_q, instret_d;
  logic [DWIDTH-1:0] tohost_q, tohost_d;

  // rs1 field is consumed upstream; it is only carried here inside inst.
  logic unused_rs1;
  assign unused_rs1 = ^inst[19:15];

  always_comb begin
    w_byte = dmem_dout[7:0];
    unique case (alu[1:0])
      2'd0: w_byte = dmem_dout[7:0];
      2'd1: w_byte = dmem_dout[15:8];
      2'd2: w_byte = dmem_dout[23:16];
      2'd3: w_byte = dmem_dout[31:24];
      default: w_byte = dmem_dout[7:0];
    endcase
    w_half = alu[1] ? dmem_dout[31:16] : dmem_dout[15:0];
    unique case (LDSel)
      c_LD_LB:  w_load = {{(DWIDTH-8){w_byte[7]}}, w_byte};
      c_LD_LBU: w_load = {{(DWIDTH-8){1'b0}}, w_byte};
      c_LD_LH:  w_load = {{(DWIDTH-16){w_half[15]}}, w_half};
      c_LD_LHU: w_load = {{(DWIDTH-16){1'b0}}, w_half};
      default:  w_load = dmem_dout;
    endcase
  end

  always_comb begin
    unique case (WBSel)
      2'b00:   rf_wd = w_load;
      2'b01:   rf_wd = alu;
      2'b10:   rf_wd = pc + DWIDTH'(4);
      default: rf_wd = '0;
    endcase
  end

  assign rf_wa = inst[11:7];
  assign rf_we = valid & RegWen & (inst[11:7] != 5'd0) & ~w_misalign;

  // csrrw (001) and csrrwi (101) both arrive with the write value already on alu.
  assign w_tohost_wr = valid && (inst[6:0] == c_OPC_SYSTEM) &&
                       (inst[31:20] == TOHOST_ADDR) &&
                       ((inst[14:12] == 3'b001) || (inst[14:12] == 3'b101));

  always_comb begin
    cycle_d   = cycle_q + DWIDTH'(1);
    instret_d = instret_q + (valid ? DWIDTH'(1) : DWIDTH'(0));
    if (counter_clr) begin
      cycle_d   = '0;
      instret_d = '0;
    end
    tohost_d = w_tohost_wr ? alu : tohost_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
      tohost_q  <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      tohost_q  <= tohost_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
  assign tohost      = tohost_q;

`ifdef WB_LOAD_MISALIGN_CHECK_EN
  logic w_is_half;
  logic w_is_word;
  logic misalign_q;

  assign w_is_half  = (LDSel == c_LD_LH) || (LDSel == c_LD_LHU);
  assign w_is_word  = !w_is_half && (LDSel != c_LD_LB) && (LDSel != c_LD_LBU);
  assign w_misalign = valid && (WBSel == 2'b00) &&
                      ((w_is_half && alu[0]) || (w_is_word && (alu[1:0] != 2'b00)));

  // Sticky until reset; counter_clr deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (w_misalign) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign w_misalign   = 1'b0;
  assign misalign_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage; consumes the EXM/WB pipeline register outputs (pc, alu, LDSel, WBSel, RegWen, inst) and the synchronous data-memory read data.
- Extracts and extends load data, selects the writeback value and drives the register-file write port and the EX forwarding path.
- Owns the architectural cycle counter, retired-instruction counter and tohost CSR (0x51E).

Parameters:
- DWIDTH, 32, datapath width; only 32 supported
- TOHOST_ADDR, 12'h51E, CSR address captured by csrrw/csrrwi

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- valid  input  1  stage holds a real instruction (0 = bubble/flushed)
- pc  input  32  pc of WB instruction
- alu  input  32  ALU result; load/store address for loads; CSR write value for CSR instructions
- LDSel  input  3  load type, funct3 coding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW
- WBSel  input  2  00 load data, 01 alu, 10 pc+4, 11 zero
- RegWen  input  1  instruction writes rd
- inst  input  32  instruction word
- dmem_dout  input  32  word read from dmem at alu[31:2]
- counter_clr  input  1  MMIO counter-reset strobe from EXM stage
- rf_we  output  1  register-file write enable
- rf_wa  output  5  destination register, inst[11:7]
- rf_wd  output  32  writeback data; also the WB forwarding value
- cycle_cnt  output  32  cycle counter
- instret_cnt  output  32  retired-instruction counter
- tohost  output  32  tohost CSR value
- misalign_err  output  1  sticky misaligned-load flag (tied 0 when feature off)

Behaviour:
- rf_we, rf_wa and rf_wd are combinational, same cycle; the register file samples them on the next edge.
- rf_we = valid & RegWen & (inst[11:7] != 0); rf_wa = inst[11:7] always.
- Load extraction, with off = alu[1:0]:
  - LB/LBU: byte dmem_dout[8*off+7 : 8*off], sign- or zero-extended.
  - LH/LHU: halfword at alu[1], sign- or zero-extended; alu[0] ignored.
  - LW: dmem_dout unmodified; alu[1:0] ignored.
- rf_wd by WBSel: 00 extracted load data, 01 alu, 10 pc+4 (mod 2^32, so pc 0xFFFF_FFFC gives 0), 11 0.
- cycle_cnt: +1 every clock, wraps 0xFFFF_FFFF -> 0.
- instret_cnt: +1 on each edge where valid=1; wraps.
- counter_clr=1: both counters load 0 on that edge. Clear wins over increment, so the next cycle reads 0 and counting resumes after.
- tohost: loads on the edge where valid=1, inst[6:0]=7'h73, inst[31:20]=TOHOST_ADDR and inst[14:12] is 001 or 101. Loaded value is alu; EX has already formed rs1 or zero-extended zimm. Other CSR addresses and funct3 values are ignored.
- Reset (rst=1 at an edge): cycle_cnt, instret_cnt, tohost, misalign_err all 0. Reset overrides counter_clr and tohost writes. Counting resumes on the first edge with rst=0, so the first post-reset edge gives cycle_cnt=1.
- Bubbles (valid=0): no rf write, no instret increment, no tohost write; cycle_cnt still increments.

Optional Feature:
- Macro: WB_LOAD_MISALIGN_CHECK_EN
- Defined:
  - A load (WBSel=00, valid=1) is misaligned when LH/LHU has alu[0]=1, or LW has alu[1:0]!=0.
  - A misaligned load forces rf_we=0 that cycle.
  - misalign_err is set on that edge and holds until rst; counter_clr does not affect it.
  - instret_cnt still increments for the faulting load.
- Undefined: misalign_err is constant 0; misaligned loads are handled as described in Behaviour.

Test Plan:
- Reset and counting: hold rst for 3 edges, release. After 5 edges cycle_cnt=5, instret_cnt=0, tohost=0, rf_we=0 while valid=0.
- Load extraction: dmem_dout=0x8765_F0A1.
  - LB off=0 -> rf_wd=0xFFFF_FFA1; LBU off=1 -> 0x0000_00F0.
  - LH alu[1]=1 -> 0xFFFF_8765; LHU alu[1]=0 -> 0x0000_F0A1; LW -> 0x8765_F0A1.
- WB mux and x0: WBSel=10, pc=0x0000_1000 -> rf_wd=0x0000_1004. WBSel=01, alu=0x1837 -> 0x1837. inst rd=0 with RegWen=1 -> rf_we=0.
- tohost: valid csrrw inst 0x51E0_9073 with alu=0x0000_0001 -> tohost=1 after the edge. The same inst with csr 0x51F, or with valid=0, leaves tohost unchanged.
- Counters:
  - 10 valid cycles then counter_clr pulse -> both counters 0 the next cycle.
  - Preload via 2^32-1 cycles, or force in sim -> cycle_cnt wraps to 0.
  - counter_clr asserted together with rst -> all 0.
- Misalign (macro defined): LW with alu=0x0000_0102 -> rf_we=0, misalign_err=1 persisting through counter_clr and cleared only by rst. With the macro undefined, the same case gives rf_we=1, rf_wd=dmem_dout, misalign_err=0.
